// File: rtl/myriadrf_spi_arb_if.sv
// Signal bundle for the LMS6002D SPI arbiter: two requester ports, the ownership
// select and the four SPI pins. The arbiter uses the slave modport.
interface myriadrf_spi_arb_if;
  logic        spi_sel_i;
  logic        req0_valid_i;
  logic [15:0] req0_dat_i;
  logic        req0_ready_o;
  logic        req0_done_o;
  logic [7:0]  req0_rdat_o;
  logic        req1_valid_i;
  logic [15:0] req1_dat_i;
  logic        req1_ready_o;
  logic        req1_done_o;
  logic [7:0]  req1_rdat_o;
  logic        spi_sclk_o;
  logic        spi_sen_o;
  logic        spi_sdio_o;
  logic        spi_sdo_i;
  logic        busy_o;

  modport slave (
    input  spi_sel_i, req0_valid_i, req0_dat_i, req1_valid_i, req1_dat_i, spi_sdo_i,
    output req0_ready_o, req0_done_o, req0_rdat_o,
    output req1_ready_o, req1_done_o, req1_rdat_o,
    output spi_sclk_o, spi_sen_o, spi_sdio_o, busy_o
  );

  modport master (
    output spi_sel_i, req0_valid_i, req0_dat_i, req1_valid_i, req1_dat_i, spi_sdo_i,
    input  req0_ready_o, req0_done_o, req0_rdat_o,
    input  req1_ready_o, req1_done_o, req1_rdat_o,
    input  spi_sclk_o, spi_sen_o, spi_sdio_o, busy_o
  );
endinterface

// File: rtl/myriadrf_spi_arb.sv
// Two-requester arbiter and SPI master for the LMS6002D serial port: one 16-bit frame
// per grant, MSB first, last 8 captured bits returned to the frame's owner.
module myriadrf_spi_arb #(
  parameter int CLK_DIV = 4,
  parameter int FRAME_W = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  myriadrf_spi_arb_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_W - 1);

  state_t             state, state_nxt;
  logic [7:0]         div_cnt;
  logic               phase;      // 0 = SCLK high half of a bit period
  logic [3:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [7:0]         cap, rdat0, rdat1;
  logic               owner, last_grant;
  logic               grant0, grant1, div_end;

  assign div_end = (div_cnt == DIV_LAST);

  // Grants are gated by reset so ready stays low while the block is held in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && wb_rst_ni) begin
      if (bus.spi_sel_i) begin
        grant1 = bus.req1_valid_i;
      end else if (bus.req0_valid_i && bus.req1_valid_i) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_valid_i;
        grant1 = bus.req1_valid_i;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nxt = SETUP;
      SETUP:   if (div_end) state_nxt = SHIFT;
      SHIFT:   if (div_end && phase && bit_cnt == BIT_LAST) state_nxt = HOLD;
      HOLD:    if (div_end) state_nxt = GAP;
      GAP:     if (div_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      div_cnt    <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cap        <= '0;
      rdat0      <= '0;
      rdat1      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      div_cnt <= (state == IDLE || div_end) ? 8'd0 : div_cnt + 8'd1;
      if (state == IDLE) begin
        bit_cnt <= '0;
        phase   <= 1'b0;
      end
      if (grant0 || grant1) begin
        shreg      <= grant1 ? bus.req1_dat_i : bus.req0_dat_i;
        owner      <= grant1;
        last_grant <= grant1;
      end
      if (state == SHIFT && !phase && div_cnt == 8'd0)
        cap <= {cap[6:0], bus.spi_sdo_i};
      // Falling edge advances SDIO, except the last one so bit 0 is held through HOLD.
      if (state == SHIFT && div_end) begin
        phase <= !phase;
        if (phase) begin
          if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt != BIT_LAST) begin
          shreg <= {shreg[FRAME_W-2:0], 1'b0};
        end
      end
      if (state == HOLD && div_end) begin
        if (owner) rdat1 <= cap;
        else       rdat0 <= cap;
      end
    end
  end

  assign bus.req0_ready_o = grant0;
  assign bus.req1_ready_o = grant1;
  assign bus.req0_done_o  = (state == GAP) && (div_cnt == 8'd0) && !owner;
  assign bus.req1_done_o  = (state == GAP) && (div_cnt == 8'd0) && owner;
  assign bus.req0_rdat_o  = rdat0;
  assign bus.req1_rdat_o  = rdat1;
  assign bus.spi_sclk_o   = (state == SHIFT) && !phase;
  assign bus.spi_sen_o    = !(state == SETUP || state == SHIFT || state == HOLD);
  assign bus.spi_sdio_o   = shreg[FRAME_W-1];
  assign bus.busy_o       = (state != IDLE);
endmodule

// File: tb/tb_myriadrf_spi_arb.sv
// Bench for myriadrf_spi_arb: CLK_DIV=2 and CLK_DIV=1 instances share stimulus; a
// frame-timeline model checks the selected one every cycle, plus literal scenario checks.
module tb_myriadrf_spi_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0, v0 = 1'b0, v1 = 1'b0, sdo = 1'b0, dsel = 1'b0;
  logic [15:0] d0 = '0, d1 = '0, slave_next = 16'h1234;
  int          cyc = 0;
  int          checks = 0, errors = 0;

  myriadrf_spi_arb_if if2 ();
  myriadrf_spi_arb_if if1 ();

  assign if2.spi_sel_i = sel;  assign if1.spi_sel_i = sel;
  assign if2.req0_valid_i = v0; assign if1.req0_valid_i = v0;
  assign if2.req1_valid_i = v1; assign if1.req1_valid_i = v1;
  assign if2.req0_dat_i = d0;  assign if1.req0_dat_i = d0;
  assign if2.req1_dat_i = d1;  assign if1.req1_dat_i = d1;
  assign if2.spi_sdo_i = sdo;  assign if1.spi_sdo_i = sdo;

  myriadrf_spi_arb #(.CLK_DIV(2), .FRAME_W(16)) u_dut2 (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(if2.slave));
  myriadrf_spi_arb #(.CLK_DIV(1), .FRAME_W(16)) u_dut1 (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(if1.slave));

  logic       o_r0, o_r1, o_d0, o_d1, o_sclk, o_sen, o_sdio, o_busy;
  logic [7:0] o_rd0, o_rd1;
  assign o_r0   = dsel ? if1.req0_ready_o : if2.req0_ready_o;
  assign o_r1   = dsel ? if1.req1_ready_o : if2.req1_ready_o;
  assign o_d0   = dsel ? if1.req0_done_o  : if2.req0_done_o;
  assign o_d1   = dsel ? if1.req1_done_o  : if2.req1_done_o;
  assign o_rd0  = dsel ? if1.req0_rdat_o  : if2.req0_rdat_o;
  assign o_rd1  = dsel ? if1.req1_rdat_o  : if2.req1_rdat_o;
  assign o_sclk = dsel ? if1.spi_sclk_o   : if2.spi_sclk_o;
  assign o_sen  = dsel ? if1.spi_sen_o    : if2.spi_sen_o;
  assign o_sdio = dsel ? if1.spi_sdio_o   : if2.spi_sdio_o;
  assign o_busy = dsel ? if1.busy_o       : if2.busy_o;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Event logs of the selected instance, sampled mid-cycle.
  int          rdy_id[$], rdy_cyc[$], done_id[$], done_cyc[$], done_rd[$];
  int          sclk_rises = 0, gap_cnt = 0;
  logic [15:0] sdio_log = '0;
  logic        prev_sclk = 1'b0;

  initial forever begin
    @(negedge clk);
    if (o_r0) begin rdy_id.push_back(0); rdy_cyc.push_back(cyc); end
    if (o_r1) begin rdy_id.push_back(1); rdy_cyc.push_back(cyc); end
    if (o_d0) begin done_id.push_back(0); done_cyc.push_back(cyc); done_rd.push_back(int'(o_rd0)); end
    if (o_d1) begin done_id.push_back(1); done_cyc.push_back(cyc); done_rd.push_back(int'(o_rd1)); end
    if (o_sclk && !prev_sclk) begin
      sclk_rises++;
      sdio_log = {sdio_log[14:0], o_sdio};
    end
    prev_sclk = o_sclk;
    if (o_busy && o_sen) gap_cnt++;
  end

  task automatic clear_logs();
    rdy_id.delete(); rdy_cyc.delete(); done_id.delete(); done_cyc.delete(); done_rd.delete();
    sclk_rises = 0; gap_cnt = 0; sdio_log = '0;
  endtask

  // Model: a frame is a timeline indexed by the offset t from its accept cycle.
  int          t = 0, tn, g, nf, dv;
  logic        lastg = 1'b1, own = 1'b0, last_bit = 1'b0, hi;
  logic [15:0] word = '0, slave_word = '0;
  logic [7:0]  rd_exp [2];
  logic        e_r0, e_r1, e_d0, e_d1, e_sclk, e_sen, e_sdio, e_busy;

  initial begin
    rd_exp[0] = '0;
    rd_exp[1] = '0;
    forever begin
      @(negedge clk);
      dv = dsel ? 1 : 2;
      e_r0 = 0; e_r1 = 0; e_d0 = 0; e_d1 = 0; e_sclk = 0; e_sen = 1; e_busy = 0;
      e_sdio = last_bit; hi = 0; tn = 0;
      if (!rst_n) begin
        lastg = 1; last_bit = 0; e_sdio = 0; rd_exp[0] = '0; rd_exp[1] = '0;
      end else if (t == 0) begin
        g = -1;
        if (sel)           begin if (v1) g = 1; end
        else if (v0 && v1) g = lastg ? 0 : 1;
        else if (v0)       g = 0;
        else if (v1)       g = 1;
        if (g >= 0) begin
          e_r0 = (g == 0); e_r1 = (g == 1);
          own = (g == 1); lastg = own;
          word = own ? d1 : d0;
          slave_word = slave_next;
          tn = 1;
        end
      end else begin
        e_busy = 1;
        e_sen  = (t > 34*dv);
        hi     = (t >= dv+1) && (t <= 33*dv) && (((t-dv-1) % (2*dv)) < dv);
        e_sclk = hi;
        nf = (t >= 2*dv+1) ? (t-2*dv-1)/(2*dv) + 1 : 0;
        if (nf > 15) nf = 15;
        e_sdio = word[15-nf];
        if (t == 34*dv+1) begin
          rd_exp[own] = slave_word[7:0];
          e_d0 = !own; e_d1 = own;
        end
        if (t == 35*dv) last_bit = word[0];
        tn = (t == 35*dv) ? 0 : t + 1;
      end
      chk("ready0", 32'(o_r0), 32'(e_r0));
      chk("ready1", 32'(o_r1), 32'(e_r1));
      chk("done0",  32'(o_d0), 32'(e_d0));
      chk("done1",  32'(o_d1), 32'(e_d1));
      chk("sclk",   32'(o_sclk), 32'(e_sclk));
      chk("sen",    32'(o_sen),  32'(e_sen));
      chk("sdio",   32'(o_sdio), 32'(e_sdio));
      chk("busy",   32'(o_busy), 32'(e_busy));
      chk("rdat0",  32'(o_rd0), 32'(rd_exp[0]));
      chk("rdat1",  32'(o_rd1), 32'(rd_exp[1]));
      // Slave holds its bit across the SCLK-high half and drives noise otherwise.
      sdo = hi ? slave_word[15 - (t-dv-1)/(2*dv)] : 1'($urandom);
      t = tn;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 19) == 0) sel = ~sel;
      if ($urandom_range(0, 3) == 0)  v0 = ~v0;
      if ($urandom_range(0, 3) == 0)  v1 = ~v1;
      d0 = 16'($urandom); d1 = 16'($urandom); slave_next = 16'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      cycles(1);
    end
    v0 = 0; v1 = 0; sel = 0; rst_n = 1;
    cycles(80);
  endtask

  int n, tgt;

  initial begin
    v0 = 1;
    cycles(3);
    chk("rst_sen",   32'(o_sen), 32'd1);
    chk("rst_sclk",  32'(o_sclk), 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_r0), 32'd0);
    chk("rst_rdat0", 32'(o_rd0), 32'd0);
    v0 = 0; rst_n = 1;

    // Write frame from requester 0, CLK_DIV=2.
    clear_logs(); d0 = 16'h8A5C; slave_next = 16'h1234; v0 = 1;
    cycles(1); v0 = 0; cycles(80);
    chk("t1_rdy_cnt", 32'(rdy_id.size()), 32'd1);
    chk("t1_rdy_id", 32'(qat(rdy_id, 0)), 32'd0);
    chk("t1_latency", 32'(qat(done_cyc, 0) - qat(rdy_cyc, 0)), 32'd69);
    chk("t1_sdio_bits", 32'(sdio_log), 32'h8A5C);
    chk("t1_rises", 32'(sclk_rises), 32'd16);
    chk("t1_sen_gap", 32'(gap_cnt), 32'd2);
    chk("t1_rdat0", 32'(o_rd0), 32'h34);

    // Read frame from requester 1; slave returns 0xC3 in the data byte.
    clear_logs(); d1 = 16'h0300; slave_next = 16'h00C3; v1 = 1;
    cycles(1); v1 = 0; cycles(80);
    chk("t2_rdy_id", 32'(qat(rdy_id, 0)), 32'd1);
    chk("t2_done_id", 32'(qat(done_id, 0)), 32'd1);
    chk("t2_done_rdat", 32'(qat(done_rd, 0)), 32'hC3);
    chk("t2_rdat1", 32'(o_rd1), 32'hC3);
    chk("t2_rdat0", 32'(o_rd0), 32'h34);

    // Both valid from reset: alternate grants 71 cycles apart.
    rst_n = 0; v0 = 1; v1 = 1; d0 = 16'hA001; d1 = 16'h5002;
    cycles(2); rst_n = 1; clear_logs();
    cycles(284); v0 = 0; v1 = 0;
    chk("t3_cnt", 32'(rdy_id.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_order", 32'(qat(rdy_id, i)), 32'(i % 2));
    for (int i = 1; i < 4; i++) chk("t3_spacing", 32'(qat(rdy_cyc, i) - qat(rdy_cyc, i-1)), 32'd71);
    cycles(80);

    // Exclusive mode, then select dropped mid-frame.
    clear_logs(); sel = 1; v0 = 1; v1 = 1;
    cycles(150);
    chk("t4_cnt", 32'(rdy_id.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t4_only1", 32'(qat(rdy_id, i)), 32'd1);
    chk("t4_midframe", 32'(o_busy), 32'd1);
    sel = 0; clear_logs();
    cycles(70);
    chk("t4_req0_next", 32'(qat(rdy_id, 0)), 32'd0);
    v0 = 0; v1 = 0; cycles(80);

    // Asynchronous reset while SCLK is high during bit 7.
    clear_logs(); d0 = 16'h9F0F; v0 = 1;
    cycles(1); v0 = 0;
    n = 0;
    while (rdy_cyc.size() == 0 && n < 20) begin @(negedge clk); n++; end
    chk("t5_accept", 32'(rdy_cyc.size()), 32'd1);
    tgt = qat(rdy_cyc, 0) + 31;
    n = 0;
    while (cyc != tgt && n < 100) begin @(negedge clk); n++; end
    chk("t5_sclk_pre", 32'(o_sclk), 32'd1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("t5_sen_async", 32'(o_sen), 32'd1);
    chk("t5_sclk_async", 32'(o_sclk), 32'd0);
    chk("t5_busy_async", 32'(o_busy), 32'd0);
    cycles(2);
    chk("t5_no_done", 32'(done_id.size()), 32'd0);
    rst_n = 1; clear_logs(); d0 = 16'h8123; slave_next = 16'h5A66; v0 = 1;
    cycles(1); v0 = 0; cycles(80);
    chk("t5_fresh_done", 32'(done_id.size()), 32'd1);
    chk("t5_fresh_rdat", 32'(o_rd0), 32'h66);

    // CLK_DIV=1 instance, requester 0 held valid for three frames.
    rst_n = 0; dsel = 1;
    cycles(2); rst_n = 1; clear_logs(); d0 = 16'hC55A; v0 = 1;
    cycles(90); v0 = 0; cycles(40);
    chk("t6_ready_cnt", 32'(rdy_id.size()), 32'd3);
    chk("t6_done_cnt", 32'(done_id.size()), 32'd3);
    chk("t6_sen_gap", 32'(gap_cnt), 32'd3);
    chk("t6_rises", 32'(sclk_rises), 32'd48);
    chk("t6_latency", 32'(qat(done_cyc, 0) - qat(rdy_cyc, 0)), 32'd35);

    // Randomised traffic on both divider settings.
    rand_run(1500);
    rst_n = 0; dsel = 0;
    cycles(2); rst_n = 1;
    rand_run(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/myriadrf_spi_arb.md
Name: myriadrf_spi_arb

Overview:
- Shared SPI master for the LMS6002D transceiver serial port on the MyriadRF board.
- Arbitrates between two requesters: requester 0 is the CPU-side SPI bridge; requester 1 is the hardware calibration/auto-config engine.
- Serialises one 16-bit LMS frame per grant and returns read data.
- Ownership policy comes from the spi_sel bit in the MyriadRF config register block.

Parameters:
- CLK_DIV, 4: SCLK half-period in wb_clk_i cycles; legal range 1..255.
- FRAME_W, 16: frame length in bits. Bit 15 = write flag (1 = write), bits 14:8 = address, bits 7:0 = data. Fixed at 16 for LMS6002D.

Ports:
- wb_clk_i, in, 1: the only clock.
- wb_rst_ni, in, 1: reset, asynchronous, active-low.
- spi_sel_i, in, 1: 0 = round-robin between requesters; 1 = requester 1 exclusive.
- req0_valid_i, in, 1: requester 0 has a frame pending.
- req0_dat_i, in, 16: requester 0 frame.
- req0_ready_o, out, 1: one-cycle accept pulse for requester 0.
- req0_done_o, out, 1: one-cycle completion pulse for requester 0.
- req0_rdat_o, out, 8: last 8 bits captured during requester 0's most recent frame.
- req1_valid_i, req1_dat_i, req1_ready_o, req1_done_o, req1_rdat_o: same as requester 0, for requester 1.
- spi_sclk_o, out, 1: serial clock; idles low.
- spi_sen_o, out, 1: chip enable, active-low.
- spi_sdio_o, out, 1: master data out, MSB first.
- spi_sdo_i, in, 1: slave data in.
- busy_o, out, 1: high whenever state is not IDLE.

Behaviour:
- Interface: one clock (wb_clk_i); reset is asynchronous and active-low (wb_rst_ni).
- Reset values, applied immediately on wb_rst_ni low, including mid-frame:
  - state = IDLE; spi_sen_o = 1; spi_sclk_o = 0; spi_sdio_o = 0.
  - All ready/done outputs = 0; both rdat = 0; busy_o = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - An aborted frame produces no done pulse.
- FSM states and transitions:
  - IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE, arbitration (evaluated each cycle):
  - spi_sel_i = 1: only req1_valid_i is considered; req0 waits with ready low.
  - spi_sel_i = 0, one requester valid: that requester is granted.
  - spi_sel_i = 0, both valid: the requester that is not last_grant wins.
  - On grant, in the same cycle:
    - ready pulses for the granted requester;
    - dat is latched into the shift register;
    - last_grant is updated;
    - next state = SETUP; spi_sen_o = 0 and spi_sdio_o = bit 15 from the next cycle.
  - Frame data is sampled only in the accept cycle. Valid deasserted before grant means no transaction.
- SETUP: CLK_DIV cycles with spi_sen_o = 0 and spi_sclk_o = 0.
- SHIFT: 16 bit periods of 2*CLK_DIV cycles each.
  - spi_sclk_o is high for the first CLK_DIV cycles, then low for CLK_DIV cycles.
  - On each rising edge, spi_sdo_i is sampled into the capture register.
  - On each falling edge, spi_sdio_o advances to the next bit. After the 16th falling edge spi_sdio_o holds bit 0.
  - A 4-bit bit counter and an 8-bit divider counter run here; neither may wrap mid-frame.
- HOLD: CLK_DIV cycles, spi_sclk_o = 0, spi_sen_o = 0.
- GAP:
  - Entry cycle: spi_sen_o = 1; the granted requester's done pulses for exactly 1 cycle; its rdat updates in that same cycle to the bits captured at rising edges 9..16 (MSB = edge 9).
  - rdat is updated for both reads and writes.
  - The other requester's rdat is unchanged.
  - GAP lasts CLK_DIV cycles, which is the minimum SEN-high time. Then IDLE.
- Latency:
  - Accept = cycle 0.
  - Done at cycle 34*CLK_DIV + 1.
  - Next earliest accept at cycle 35*CLK_DIV + 1.
- Other rules:
  - Changing spi_sel_i mid-frame does not affect the current frame; it is evaluated at the next IDLE.
  - ready and done never assert for both requesters in the same cycle.

Test Plan:
1. CLK_DIV=2, spi_sel_i=0, req0 writes 0x8A5C -> req0_ready_o at cycle 0; SDIO bits 1000101001011100 on 16 SCLK rising edges, period 4 cycles; req0_done_o at cycle 69; SEN high 2 cycles before busy_o drops.
2. req1 reads 0x0300, slave drives 0xC3 on the last 8 bits -> req1_rdat_o = 0xC3 at the req1_done_o pulse; req0_rdat_o unchanged.
3. spi_sel_i=0, both valid continuously from reset -> grant order 0,1,0,1; each grant separated by 35*CLK_DIV+1 cycles.
4. spi_sel_i=1, both valid -> only req1 granted, repeatedly; req0_ready_o stays 0. Drop spi_sel_i to 0 mid-frame -> req0 granted next.
5. Assert wb_rst_ni low during SHIFT bit 7 -> spi_sen_o = 1 and spi_sclk_o = 0 without waiting for a clock edge; no done pulse; after release a fresh req0 frame completes normally.
6. CLK_DIV=1, req0_valid_i held high for 3 frames -> 3 ready and 3 done pulses; SEN-high gap = 1 cycle; no SCLK pulse lost.
